// File: rtl/reg_file_arbiter_pkg.sv
// Shared types and default sizes for the register-file arbiter.
//   state_e : top-level sequencing (INIT clear sweep, then RUN arbitration)
//   pri_e   : round-robin priority pointer value
//   entry_t : one register-file entry, WIDTH_VECTOR lanes of N bits
package reg_file_arbiter_pkg;

  localparam int unsigned DEF_WIDTH_ADDR   = 4;
  localparam int unsigned DEF_WIDTH_VECTOR = 8;
  localparam int unsigned DEF_N            = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    PRI_WR = 1'b0,
    PRI_RD = 1'b1
  } pri_e;

  typedef logic [DEF_WIDTH_VECTOR-1:0][DEF_N-1:0] entry_t;

endpackage

// File: rtl/reg_file_arbiter_rsp_fifo.sv
// Read-response FIFO with a register-backed head.
//   clk, rst          : clock, async active-high reset
//   push, push_data   : enqueue one response
//   pop               : dequeue head (ignored when empty)
//   valid, data       : head present / head entry (zero after reset)
//   count             : current occupancy
module rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         valid,
  output logic [WIDTH-1:0]             data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/occupancy update; a simultaneous push and pop keeps count.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign data  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/reg_file_arbiter.sv
// Single-port register-file arbiter: clears the file after reset, then
// grants one read or write per cycle with round-robin priority on conflicts.
//   clk, rst                     : clock, async active-high reset
//   wr_valid/wr_ready, wr_addr,
//   wr_data                      : write request, granted same cycle
//   rd_valid/rd_ready, rd_addr   : read request, throttled by response space
//   rsp_valid/rsp_ready, rsp_data: in-order read responses
//   rf_we, rf_addr, rf_wdata,
//   rf_rdata                     : register-file port (RD_LAT read latency)
//   init_done                    : clear sweep finished
module reg_file_arbiter
  import reg_file_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR   = DEF_WIDTH_ADDR,
  parameter int unsigned WIDTH_VECTOR = DEF_WIDTH_VECTOR,
  parameter int unsigned N            = DEF_N,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [WIDTH_ADDR-1:0]        wr_addr,
  input  logic [WIDTH_VECTOR*N-1:0]    wr_data,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [WIDTH_ADDR-1:0]        rd_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH_VECTOR*N-1:0]    rsp_data,
  output logic                         rf_we,
  output logic [WIDTH_ADDR-1:0]        rf_addr,
  output logic [WIDTH_VECTOR*N-1:0]    rf_wdata,
  input  logic [WIDTH_VECTOR*N-1:0]    rf_rdata,
  output logic                         init_done
);

  localparam int unsigned DW         = WIDTH_VECTOR * N;
  localparam int unsigned FIFO_DEPTH = RD_LAT + 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [WIDTH_ADDR-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic [WIDTH_ADDR-1:0] init_addr_q, init_addr_d;
  pri_e                  pri_q, pri_d;
  logic [RD_LAT-1:0]     inflight_q, inflight_d;

  logic [CNT_W-1:0]      fifo_count;
  int unsigned           pending;
  logic                  rd_elig;
  logic                  contested;
  logic                  rd_grant;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: sweep every address once, then run forever.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + WIDTH_ADDR'(1);
        if (init_addr_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Responses owed = queued in FIFO + still inside the RF read pipe.
  always_comb begin
    pending = 32'(fifo_count);
    for (int i = 0; i < int'(RD_LAT); i++) pending += 32'(inflight_q[i]);
  end

  assign rd_elig = (state_q == ST_RUN) && (pending < FIFO_DEPTH);

  // Outputs and arbitration. The rst gate keeps the RF port quiet while
  // reset is held, since INIT itself drives rf_we high.
  always_comb begin
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    rf_we     = 1'b0;
    rf_addr   = '0;
    rf_wdata  = '0;
    rd_grant  = 1'b0;
    pri_d     = pri_q;
    contested = wr_valid && rd_valid && rd_elig;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        rf_we   = 1'b1;
        rf_addr = init_addr_q;
      end else begin
        wr_ready = !(rd_valid && rd_elig) || (pri_q == PRI_WR);
        rd_ready = rd_elig && (!wr_valid || (pri_q == PRI_RD));
        rd_grant = rd_valid && rd_ready;
        if (wr_valid && wr_ready) begin
          rf_we    = 1'b1;
          rf_addr  = wr_addr;
          rf_wdata = wr_data;
        end else if (rd_grant) begin
          rf_addr = rd_addr;
        end
        if (contested) pri_d = (pri_q == PRI_WR) ? PRI_RD : PRI_WR;
      end
    end
  end

  // One valid bit per read travelling through the RF latency.
  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = rd_grant;
    for (int i = 1; i < int'(RD_LAT); i++) inflight_d[i] = inflight_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_addr_q <= '0;
      pri_q       <= PRI_WR;
      inflight_q  <= '0;
    end else begin
      init_addr_q <= init_addr_d;
      pri_q       <= pri_d;
      inflight_q  <= inflight_d;
    end
  end

  assign init_done = (state_q == ST_RUN);

  rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q[RD_LAT-1]),
    .push_data (rf_rdata),
    .pop       (rsp_valid && rsp_ready),
    .valid     (rsp_valid),
    .data      (rsp_data),
    .count     (fifo_count)
  );

endmodule
